// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: serial input, configuration and status.
interface seq_detector_param_if #(
  parameter int unsigned PATTERN_W = 4,
  parameter int unsigned CNT_W     = 8
);
  logic                 in_valid;
  logic                 in;
  logic                 cfg_load;
  logic [PATTERN_W-1:0] cfg_pattern;
  logic                 cfg_overlap;
  logic                 clr_count;
  logic                 match;
  logic [CNT_W-1:0]     match_count;
  logic                 count_sat;
  logic                 armed;

  modport master (
    output in_valid, in, cfg_load, cfg_pattern, cfg_overlap, clr_count,
    input  match, match_count, count_sat, armed
  );

  modport slave (
    input  in_valid, in, cfg_load, cfg_pattern, cfg_overlap, clr_count,
    output match, match_count, count_sat, armed
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern,
// overlap/non-overlap mode and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned          PATTERN_W       = 4,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = 4'b1011,
  parameter logic                 DEFAULT_OVERLAP = 1'b1,
  parameter int unsigned          CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_e;

  localparam int unsigned           FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(PATTERN_W);
  localparam logic [FILL_W-1:0]     FILL_LAST = FILL_W'(PATTERN_W - 1);

  // Only the newest PATTERN_W-1 bits are stored; the incoming bit completes the window.
  logic [PATTERN_W-2:0] shreg_q, shreg_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  state_e               state_q, state_d;
  logic [PATTERN_W-1:0] pattern_q;
  logic                 overlap_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic                 match_q;
  logic                 armed_q;

  logic [PATTERN_W-1:0] window;
  logic                 accept;
  logic                 hit;

  assign window = {shreg_q, bus.in};
  assign accept = bus.in_valid & ~bus.cfg_load;
  assign hit    = accept && (fill_q == FILL_LAST || state_q == ARMED) && (window == pattern_q);

  // Next-state for shift register, fill level, FSM state and counter.
  always_comb begin
    shreg_d = shreg_q;
    fill_d  = fill_q;
    state_d = state_q;
    cnt_d   = bus.clr_count ? '0 : cnt_q;
    sat_d   = bus.clr_count ? 1'b0 : sat_q;

    if (bus.cfg_load) begin
      shreg_d = '0;
      fill_d  = '0;
      state_d = EMPTY;
    end else if (accept) begin
      shreg_d = window[PATTERN_W-2:0];
      fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      state_d = (fill_d == FILL_FULL) ? ARMED : FILLING;
      if (hit && !overlap_q) begin
        shreg_d = '0;
        fill_d  = '0;
        state_d = EMPTY;
      end
    end

    // Clear is applied first, so a coincident hit leaves the count at one.
    if (hit) begin
      if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
      if (cnt_d == '1) sat_d = 1'b1;
    end
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      fill_q    <= '0;
      state_q   <= EMPTY;
      pattern_q <= DEFAULT_PATTERN;
      overlap_q <= DEFAULT_OVERLAP;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      match_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      match_q <= hit;
      armed_q <= (state_d == ARMED);
      if (bus.cfg_load) begin
        pattern_q <= bus.cfg_pattern;
        overlap_q <= bus.cfg_overlap;
      end
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;
  assign bus.armed       = armed_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic,
// checked every cycle against a bit-history model.
module tb_seq_detector_param;

  localparam int unsigned PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PATTERN_W(PW), .CNT_W(8)) bus8 ();
  seq_detector_param_if #(.PATTERN_W(PW), .CNT_W(2)) bus2 ();

  seq_detector_param #(.PATTERN_W(PW), .DEFAULT_PATTERN(4'b1011),
                       .DEFAULT_OVERLAP(1'b1), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8));

  seq_detector_param #(.PATTERN_W(PW), .DEFAULT_PATTERN(4'b1011),
                       .DEFAULT_OVERLAP(1'b1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: history of accepted bits since the last restart.
  bit       hist[$];
  bit [3:0] m_pat;
  bit       m_ovl;
  int       m_cnt8, m_cnt2;
  bit       m_sat8, m_sat2;
  bit       e_match, e_armed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit b, input bit ld,
                       input bit [3:0] pat, input bit ovl, input bit clr);
    bit       hit;
    bit [3:0] w;
    hit = 1'b0;
    if (r) begin
      hist.delete();
      m_pat = 4'b1011; m_ovl = 1'b1;
      m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 0; m_sat2 = 0;
    end else begin
      if (clr) begin
        m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 0; m_sat2 = 0;
      end
      if (ld) begin
        m_pat = pat; m_ovl = ovl;
        hist.delete();
      end else if (v) begin
        if (hist.size() >= PW - 1) begin
          w = '0;
          for (int i = PW - 1; i >= 1; i--) w = {w[2:0], hist[hist.size() - i]};
          w = {w[2:0], b};
          hit = (w == m_pat);
        end
        hist.push_back(b);
        if (hist.size() > PW) void'(hist.pop_front());
        if (hit && !m_ovl) hist.delete();
      end
      if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt8 == 255) m_sat8 = 1;
        if (m_cnt2 < 3) m_cnt2++;
        if (m_cnt2 == 3) m_sat2 = 1;
      end
    end
    e_match = hit;
    e_armed = (hist.size() == PW);
  endtask

  task automatic step(input bit r, input bit v, input bit b, input bit ld,
                      input bit [3:0] pat, input bit ovl, input bit clr);
    rst = r;
    bus8.in_valid = v;  bus2.in_valid = v;
    bus8.in = b;        bus2.in = b;
    bus8.cfg_load = ld; bus2.cfg_load = ld;
    bus8.cfg_pattern = pat; bus2.cfg_pattern = pat;
    bus8.cfg_overlap = ovl; bus2.cfg_overlap = ovl;
    bus8.clr_count = clr;   bus2.clr_count = clr;
    @(posedge clk);
    model(r, v, b, ld, pat, ovl, clr);
    #1;
    chk("match8", 32'(bus8.match), 32'(e_match));
    chk("armed8", 32'(bus8.armed), 32'(e_armed));
    chk("count8", 32'(bus8.match_count), 32'(m_cnt8));
    chk("sat8",   32'(bus8.count_sat), 32'(m_sat8));
    chk("match2", 32'(bus2.match), 32'(e_match));
    chk("armed2", 32'(bus2.armed), 32'(e_armed));
    chk("count2", 32'(bus2.match_count), 32'(m_cnt2));
    chk("sat2",   32'(bus2.count_sat), 32'(m_sat2));
  endtask

  task automatic bit_in(input bit b);
    step(0, 1, b, 0, 4'h0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 4'h0, 0, 0);
    step(1, 0, 0, 0, 4'h0, 0, 0);
  endtask

  bit [6:0] stream = 7'b1011011;
  bit [3:0] t4tail = 4'b0110;

  initial begin
    bus8.in_valid = 0; bus2.in_valid = 0;
    bus8.in = 0; bus2.in = 0;
    bus8.cfg_load = 0; bus2.cfg_load = 0;
    bus8.cfg_pattern = '0; bus2.cfg_pattern = '0;
    bus8.cfg_overlap = 0; bus2.cfg_overlap = 0;
    bus8.clr_count = 0; bus2.clr_count = 0;

    // Defaults, overlapping stream: hits after bits 4 and 7.
    do_reset();
    chk("rst_armed", 32'(bus8.armed), 32'd0);
    chk("rst_count", 32'(bus8.match_count), 32'd0);
    for (int i = 6; i >= 0; i--) begin
      bit_in(stream[i]);
      if (i == 3 || i == 0) chk("t1_pulse", 32'(bus8.match), 32'd1);
    end
    chk("t1_count", 32'(bus8.match_count), 32'd2);

    // Non-overlap, same stream: single hit, count advances by one.
    step(0, 0, 0, 1, 4'b1011, 0, 0);
    for (int i = 6; i >= 0; i--) bit_in(stream[i]);
    chk("t2_count", 32'(bus8.match_count), 32'd3);

    // Gaps in in_valid do not break the window.
    do_reset();
    bit_in(1); bit_in(0);
    idle(); idle(); idle();
    bit_in(1); bit_in(1);
    chk("t3_pulse", 32'(bus8.match), 32'd1);
    chk("t3_count", 32'(bus8.match_count), 32'd1);

    // Reload discards stale bits; same-cycle bit is ignored.
    do_reset();
    bit_in(0); bit_in(1); bit_in(1);
    step(0, 1, 0, 1, 4'b0110, 1, 0);
    chk("t4_load_nomatch", 32'(bus8.match), 32'd0);
    for (int i = 3; i >= 0; i--) bit_in(t4tail[i]);
    chk("t4_pulse", 32'(bus8.match), 32'd1);
    chk("t4_count", 32'(bus8.match_count), 32'd1);

    // Saturation on the 2-bit counter, then clear.
    do_reset();
    step(0, 0, 0, 1, 4'b1111, 1, 0);
    for (int i = 0; i < 8; i++) bit_in(1);
    chk("t5_count2", 32'(bus2.match_count), 32'd3);
    chk("t5_sat2", 32'(bus2.count_sat), 32'd1);
    step(0, 0, 0, 0, 4'h0, 0, 1);
    chk("t5_clr_count2", 32'(bus2.match_count), 32'd0);
    chk("t5_clr_sat2", 32'(bus2.count_sat), 32'd0);
    // Hit coincident with clear leaves count at one.
    step(0, 1, 1, 0, 4'h0, 0, 1);
    chk("t5_hit_clr", 32'(bus2.match_count), 32'd1);

    // Reset mid-stream.
    do_reset();
    bit_in(1); bit_in(0); bit_in(1);
    step(1, 1, 1, 0, 4'h0, 0, 0);
    bit_in(1);
    chk("t6_match", 32'(bus8.match), 32'd0);
    chk("t6_armed", 32'(bus8.armed), 32'd0);
    chk("t6_count", 32'(bus8.match_count), 32'd0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 9) < 8,
           1'($urandom),
           $urandom_range(0, 49) == 0,
           4'($urandom),
           1'($urandom),
           $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
